dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, width of the load/store data.
REQ-002 The block SHALL have parameter ADDR_W, default 8, width of the data-memory address.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 15, maximum number of ACCESS cycles before an unacknowledged access is aborted.
REQ-004 The block SHALL run on one clock and use an asynchronous, active-low reset, named as the codebase names them: clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 mem_read  input  1  CPU load request, level, held until done.
REQ-007 mem_write  input  1  CPU store request, level, held until done.
REQ-008 alu_addr  input  ADDR_W  effective address from the ALU.
REQ-009 store_data  input  DATA_W  register value to store.
REQ-010 from_DMem  output  DATA_W  registered load result feeding write-back select.
REQ-011 stall  output  1  freeze pipeline while an access is pending.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 bus_err  output  1  sticky timeout or illegal-request flag.
REQ-014 dmem_req  output  1  memory request, held until ack.
REQ-015 dmem_we  output  1  1 = write, 0 = read; valid while dmem_req is high.
REQ-016 dmem_addr / dmem_wdata  output  ADDR_W / DATA_W  latched address and data.
REQ-017 dmem_ack  input  1  memory completion, one cycle.
REQ-018 dmem_rdata  input  DATA_W  read data, valid with dmem_ack.

Function
REQ-019 The FSM SHALL have the states IDLE, ACCESS and DONE.
REQ-020 In IDLE, when mem_read or mem_write is high, the block SHALL latch alu_addr, store_data and the operation, then move to ACCESS on the next edge.
REQ-021 If mem_read and mem_write are both high, the write SHALL be performed and bus_err SHALL be set.
REQ-022 In ACCESS, dmem_req SHALL be 1, dmem_we SHALL equal the latched operation, and dmem_addr/dmem_wdata SHALL stay constant.
REQ-023 stall SHALL be combinational: 1 in IDLE with a request present, and 1 throughout ACCESS; otherwise 0.
REQ-024 On dmem_ack in ACCESS, the block SHALL go to DONE; for a read, from_DMem SHALL capture dmem_rdata on that edge.
REQ-025 A write SHALL leave from_DMem unchanged.
REQ-026 In DONE, done SHALL be 1, stall and dmem_req SHALL be 0, and the state SHALL return to IDLE unconditionally; any request present in DONE SHALL be ignored.
REQ-027 Minimum latency SHALL be: request seen in IDLE at cycle 0, dmem_req at cycle 1, ack at cycle 1 gives done at cycle 2.
REQ-028 A 4-bit ACCESS cycle counter SHALL clear on entry to ACCESS.
REQ-029 If the counter reaches TIMEOUT_CYC without an ack, the block SHALL drop dmem_req, set bus_err, load from_DMem with all-ones for a read, and go to DONE.
REQ-030 An ack arriving in the same cycle as the timeout SHALL win: normal completion, no error.
REQ-031 A dmem_ack received outside ACCESS SHALL be ignored.
REQ-032 bus_err SHALL be cleared only by reset.

Reset
REQ-033 While rst_n is low, the block SHALL immediately force state IDLE and force from_DMem, stall, done, bus_err, dmem_req, dmem_we, dmem_addr, dmem_wdata and the counter to 0.
REQ-034 A reset during ACCESS SHALL abort the access with no completion pulse.

Structure
REQ-035 DATA_W/ADDR_W defaults and the IDLE/ACCESS/DONE state encoding SHALL reside in shared package mips_lite_pkg.
REQ-036 The timeout counter SHALL be sub-module dmem_timeout (inputs clear and enable; output expired).

Verification
REQ-037 Scenario: read at addr 0x10 with ack one cycle after dmem_req, rdata 0x5A -> from_DMem = 0x5A, done pulse at cycle 2, stall high for 2 cycles.
REQ-038 Scenario: write 0x0C to addr 0x04 with ack after 3 cycles -> dmem_we = 1, dmem_wdata = 0x0C held stable, from_DMem unchanged.
REQ-039 Scenario: read with no ack -> dmem_req drops after 15 ACCESS cycles, bus_err = 1, from_DMem = 0xFF, done pulses.
REQ-040 Scenario: ack coincident with cycle 15 -> normal completion, bus_err stays 0.
REQ-041 Scenario: rst_n low mid-ACCESS -> dmem_req is 0 immediately, no done pulse, all outputs are 0.
REQ-042 Scenario: mem_read and mem_write both high -> a write is issued and bus_err = 1.

Source files
------------

// File: rtl/mips_lite_pkg.sv
// Shared definitions for the mips_lite data-memory path: default widths,
// the access-timeout counter width and the controller state encoding.
package mips_lite_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 8;

    // Width of the ACCESS-cycle counter inside dmem_timeout.
    localparam int COUNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_timeout.sv
// ACCESS-cycle watchdog. The count holds the number of ACCESS cycles
// already completed, so expired is raised during the TIMEOUT_CYC-th cycle.
// The ack check in the controller takes priority over expired.
module dmem_timeout
    import mips_lite_pkg::*;
#(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [COUNT_W-1:0] LAST_CNT = COUNT_W'(TIMEOUT_CYC - 1);

    logic [COUNT_W-1:0] count_reg;

    // Count ACCESS cycles; saturate at the last value so the count never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != LAST_CNT)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = enable && (count_reg == LAST_CNT);

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: turns the CPU's level load/store request
// into a held memory request, stalls the pipeline while it is pending,
// captures load data and aborts accesses that are never acknowledged.
module dmem_ctrl
    import mips_lite_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] store_data,
    output logic [DATA_W-1:0] from_DMem,
    output logic              stall,
    output logic              done,
    output logic              bus_err,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata
);

    dmem_state_e       state_reg, state_next;
    logic              op_we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              err_reg;
    logic              req_present;
    logic              start_access;
    logic              in_access;
    logic              expired;

    assign req_present  = mem_read | mem_write;
    assign start_access = (state_reg == ST_IDLE) && req_present;
    assign in_access    = (state_reg == ST_ACCESS);

    dmem_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (start_access),
        .enable  (in_access),
        .expired (expired)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: DONE always lasts one cycle and ignores any request.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (req_present) state_next = ST_ACCESS;
            ST_ACCESS: if (dmem_ack || expired) state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; stall is also held low during reset.
    always_comb begin
        dmem_req = (state_reg == ST_ACCESS);
        done     = (state_reg == ST_DONE);
        stall    = rst_n && (start_access || in_access);
    end

    // Request latch, load-data capture and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_we_reg <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else if (start_access) begin
            // A simultaneous load and store performs the store and flags it.
            op_we_reg <= mem_write;
            addr_reg  <= alu_addr;
            wdata_reg <= store_data;
            if (mem_read && mem_write) begin
                err_reg <= 1'b1;
            end
        end else if (in_access) begin
            if (dmem_ack) begin
                if (!op_we_reg) begin
                    rdata_reg <= dmem_rdata;
                end
            end else if (expired) begin
                err_reg <= 1'b1;
                if (!op_we_reg) begin
                    rdata_reg <= '1;
                end
            end
        end
    end

    assign dmem_we    = op_we_reg;
    assign dmem_addr  = addr_reg;
    assign dmem_wdata = wdata_reg;
    assign from_DMem  = rdata_reg;
    assign bus_err    = err_reg;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl. Each transaction pushes its expected
// completion (load result, error flag) into a queue; a monitor pops and
// compares on every done pulse. The stimulus task plays the memory side.
module tb_dmem_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mem_read, mem_write;
    logic [7:0] alu_addr, store_data;
    logic [7:0] from_DMem;
    logic       stall, done, bus_err, dmem_req, dmem_we;
    logic [7:0] dmem_addr, dmem_wdata;
    logic       dmem_ack;
    logic [7:0] dmem_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] from_val;
        logic       err_val;
    } exp_t;

    exp_t sb[$];

    dmem_ctrl #(.DATA_W(8), .ADDR_W(8), .TIMEOUT_CYC(15)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .alu_addr   (alu_addr),
        .store_data (store_data),
        .from_DMem  (from_DMem),
        .stall      (stall),
        .done       (done),
        .bus_err    (bus_err),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {from_DMem, stall, done, bus_err, dmem_req, dmem_we, dmem_addr, dmem_wdata}, 32'd0);
    endtask

    // Monitor: every done pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no completion");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("mon_from_DMem", {24'd0, from_DMem}, {24'd0, e.from_val});
                chk("mon_bus_err", {31'd0, bus_err}, {31'd0, e.err_val});
                $display("MON done from_DMem=0x%02h bus_err=%0b", from_DMem, bus_err);
            end
        end
    end

    // One CPU request; ack_cyc is the ACCESS cycle (1-based) carrying the ack, 0 = never.
    task automatic do_txn(input string name, input logic rd, input logic wr,
                          input logic [7:0] addr, input logic [7:0] data,
                          input int ack_cyc, input logic [7:0] rdata,
                          input logic [7:0] exp_from, input logic exp_err,
                          input logic exp_we, input int exp_done_cyc);
        exp_t e;
        bit   got;
        int   stall_cnt;
        e.from_val = exp_from;
        e.err_val  = exp_err;
        sb.push_back(e);
        @(negedge clk);
        mem_read   = rd;
        mem_write  = wr;
        alu_addr   = addr;
        store_data = data;
        #1;
        chk({name, "_stall_idle"}, {31'd0, stall}, 32'd1);
        got       = 0;
        stall_cnt = 1;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                chk({name, "_done_cycle"}, c, exp_done_cyc);
                chk({name, "_done_idle"}, {30'd0, stall, dmem_req}, 32'd0);
                chk({name, "_stall_cycles"}, stall_cnt, exp_done_cyc);
                $display("TXN %s rd=%0b wr=%0b addr=0x%02h done at cycle %0d", name, rd, wr, addr, c);
                mem_read  = 1'b0;
                mem_write = 1'b0;
                dmem_ack  = 1'b0;
            end else begin
                if (stall) stall_cnt++;
                if (c == 1) chk({name, "_req_cycle1"}, {31'd0, dmem_req}, 32'd1);
                if (dmem_req)
                    chk({name, "_bus_hold"}, {15'd0, dmem_we, dmem_addr, dmem_wdata},
                        {15'd0, exp_we, addr, data});
                dmem_ack   = (c == ack_cyc);
                dmem_rdata = (c == ack_cyc) ? rdata : 8'h00;
            end
        end
        if (!got) begin
            chk({name, "_no_done"}, 32'd0, 32'd1);
            mem_read  = 1'b0;
            mem_write = 1'b0;
            dmem_ack  = 1'b0;
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        alu_addr   = 8'h00;
        store_data = 8'h00;
        dmem_ack   = 1'b0;
        dmem_rdata = 8'h00;
        #3;
        chk_all_zero("reset_state");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Minimum-latency read.
        do_txn("read_min", 1, 0, 8'h10, 8'h00, 1, 8'h5A, 8'h5A, 0, 0, 2);
        // Write with late ack: load result must be untouched.
        do_txn("write_ack3", 0, 1, 8'h04, 8'h0C, 3, 8'hEE, 8'h5A, 0, 1, 4);

        // Ack outside ACCESS is ignored.
        @(negedge clk);
        dmem_ack   = 1'b1;
        dmem_rdata = 8'h77;
        @(negedge clk);
        dmem_ack   = 1'b0;
        chk("stray_ack", {23'd0, from_DMem, done}, {23'd0, 8'h5A, 1'b0});

        // Ack on the last allowed cycle completes normally.
        do_txn("ack_at_15", 1, 0, 8'h20, 8'h00, 15, 8'h3C, 8'h3C, 0, 0, 16);
        // No ack at all: timeout, all-ones load result, sticky error.
        do_txn("timeout", 1, 0, 8'h30, 8'h00, 0, 8'h00, 8'hFF, 1, 0, 16);
        @(negedge clk);
        chk("err_sticky", {31'd0, bus_err}, 32'd1);

        // Reset in the middle of an access.
        @(negedge clk);
        mem_read = 1'b1;
        alu_addr = 8'h50;
        @(negedge clk);
        chk("midreset_req_before", {31'd0, dmem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset_outputs");
        mem_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midreset_no_done", {31'd0, done}, 32'd0);
        end
        $display("TXN midreset aborted read at addr 0x50");

        // Load and store together: store is performed and flagged.
        do_txn("rd_wr_both", 1, 1, 8'h44, 8'hA5, 2, 8'h99, 8'h00, 1, 1, 3);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
